// File: rtl/pc_update.sv
// Program counter with branch resolution and a three-step exception sequence (RUN -> EXC_SAVE -> EXC_VECTOR).
// Latency: a taken PC load lands one edge later; exception entry to vector load takes three edges. No backpressure: requests arriving while busy are dropped.
module pc_update #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] EXC_BASE = 32'h000000F0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic [1:0]  branch_type,
    input  logic        zero,
    input  logic        gt,
    input  logic        rfe,
    input  logic [2:0]  exc_req,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic        exc_busy,
    output logic        exc_ack
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        EXC_SAVE   = 2'd1,
        EXC_VECTOR = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  cause_q, cause_d;
    logic        exc_ack_q, exc_ack_d;

    logic        cond;
    logic        take;
    logic [1:0]  exc_idx;

    always_comb begin
        cond = 1'b0;
        case (branch_type)
            2'b00:   cond = zero;
            2'b01:   cond = ~zero;
            2'b10:   cond = gt;
            default: cond = ~gt;
        endcase
    end

    assign take = pc_write | (pc_write_cond & cond);

    // Lowest set request bit wins when several fire together.
    always_comb begin
        exc_idx = 2'd2;
        if (exc_req[0])
            exc_idx = 2'd0;
        else if (exc_req[1])
            exc_idx = 2'd1;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        exc_ack_d = 1'b0;
        case (state_q)
            RUN: begin
                if (|exc_req) begin
                    cause_d = exc_idx;
                    state_d = EXC_SAVE;
                end else if (rfe) begin
                    pc_d = epc_q;
                end else if (take) begin
                    if (next_pc[1:0] != 2'b00) begin
                        cause_d = 2'd3;
                        state_d = EXC_SAVE;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            EXC_SAVE: begin
                // Wraps at zero by design: pc=0 saves 32'hFFFFFFFC.
                epc_d   = pc_q - 32'd4;
                state_d = EXC_VECTOR;
            end
            EXC_VECTOR: begin
                pc_d      = EXC_BASE + {28'd0, cause_q, 2'b00};
                exc_ack_d = 1'b1;
                state_d   = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            epc_q     <= 32'd0;
            cause_q   <= 2'd0;
            exc_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            exc_ack_q <= exc_ack_d;
        end
    end

    assign pc       = pc_q;
    assign epc      = epc_q;
    assign cause    = cause_q;
    assign exc_ack  = exc_ack_q;
    assign exc_busy = (state_q != RUN);

endmodule
